ahb_fetch_unit: RTL and testbench

AHB_FETCH_UNIT -- requirements
Module: ahb_fetch_unit

---
 rtl/ahb_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/ahb_fetch_unit.sv | 137 +++++++++++++
 tb/tb_ahb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the fetch path: HTRANS encodings and the
// fetch-unit bus state machine states.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} pairs. Head is read straight out
// of the storage array, so a word written on a clock edge is visible at the
// head from the following cycle. Flush empties the queue in one cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             nRst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // A pop is only honoured when something is stored; a push into a full
  // queue is only honoured when the head leaves in the same cycle.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write port; contents need no reset because the head is masked.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  assign head_valid = (count_reg != '0);
  assign head_data  = head_valid ? mem[rd_ptr_reg] : '0;
  assign count      = count_reg;

endmodule

// File: rtl/ahb_fetch_unit.sv
// Instruction fetch unit: single-outstanding AHB master that keeps a small
// prefetch FIFO topped up and hands {instruction, pc} to the decoder.
// Redirects flush the FIFO immediately; a bus transfer already under way
// is allowed to finish and its data is dropped.
module ahb_fetch_unit
  import ahb_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          XLEN     = 32
) (
  input  logic            clock,
  input  logic            nRst,
  output logic            HBUSREQ1,
  input  logic            HGRANT1,
  output logic [XLEN-1:0] HADDR,
  output logic [1:0]      HTRANS,
  input  logic            HREADY,
  input  logic [XLEN-1:0] HRDATA,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  fetch_state_t      state_reg;
  logic [XLEN-1:0]   fetch_pc_reg;
  logic [XLEN-1:0]   fetch_pc_next;
  logic [XLEN-1:0]   redirect_target;
  logic              discard_reg;
  logic              capture;
  logic              push;
  logic              pop;
  logic              slot_free;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic              head_valid;
  logic [2*XLEN-1:0] head_data;
  logic              unused_ok;

  // The address of the transfer in its data phase is still on HADDR.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clock      (clock),
    .nRst       (nRst),
    .flush      (redirect),
    .push       (push),
    .push_data  ({HRDATA, HADDR}),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (count)
  );

  assign inst_valid = head_valid;
  assign inst_data  = head_data[2*XLEN-1:XLEN];
  assign inst_pc    = head_data[XLEN-1:0];
  assign unused_ok  = &{1'b0, redirect_pc[1:0]};

  // Next-cycle FIFO occupancy and fetch address; redirect overrides both.
  always_comb begin
    redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    capture         = (state_reg == ST_DATA) && HREADY;
    push            = capture && !discard_reg && !redirect;
    pop             = head_valid && inst_ready && !redirect;
    count_next      = redirect ? '0 : (count + CW'(push) - CW'(pop));
    slot_free       = (count_next < DEPTH_C);
    if (redirect) begin
      fetch_pc_next = redirect_target;
    end else if (capture && !discard_reg) begin
      fetch_pc_next = fetch_pc_reg + PC_STEP;
    end else begin
      fetch_pc_next = fetch_pc_reg;
    end
  end

  // Bus state machine with registered request, address and transfer type.
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      state_reg    <= ST_IDLE;
      fetch_pc_reg <= XLEN'(RESET_PC);
      discard_reg  <= 1'b0;
      HBUSREQ1     <= 1'b0;
      HADDR        <= '0;
      HTRANS       <= HTRANS_IDLE;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      case (state_reg)
        ST_IDLE: begin
          if (slot_free) begin
            state_reg <= ST_REQ;
            HBUSREQ1  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (HGRANT1 && HREADY) begin
            state_reg <= ST_ADDR;
            HADDR     <= fetch_pc_next;
            HTRANS    <= HTRANS_NONSEQ;
          end
        end
        ST_ADDR: begin
          state_reg <= ST_DATA;
          HTRANS    <= HTRANS_IDLE;
          if (redirect) discard_reg <= 1'b1;
        end
        ST_DATA: begin
          if (HREADY) begin
            discard_reg <= 1'b0;
            if (slot_free && HGRANT1) begin
              state_reg <= ST_ADDR;
              HADDR     <= fetch_pc_next;
              HTRANS    <= HTRANS_NONSEQ;
            end else if (slot_free) begin
              state_reg <= ST_REQ;
            end else begin
              state_reg <= ST_IDLE;
              HBUSREQ1  <= 1'b0;
            end
          end else if (redirect) begin
            discard_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_fetch_unit.sv
// Bench for ahb_fetch_unit: random AHB slave/decoder stimulus with directed
// scenarios, a scoreboard of expected {pc, data} pairs and an independent
// model of the next fetch address.
module tb_ahb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        nRst = 1'b0;
  logic        HBUSREQ1;
  logic        HGRANT1 = 1'b0;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  ahb_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .XLEN     (32)
  ) dut (
    .clock       (clock),
    .nRst        (nRst),
    .HBUSREQ1    (HBUSREQ1),
    .HGRANT1     (HGRANT1),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  int checks = 0;
  int passes = 0;

  // stimulus knobs (percent probabilities)
  int grant_pct = 100;
  int hready_pct = 100;
  int iready_pct = 100;
  int redirect_pct = 0;
  int data_mode = 0;

  // reference model state
  exp_t        exp_q[$];
  logic [31:0] issue_log[$];
  logic [31:0] model_pc = RESET_PC;
  logic        data_active = 1'b0;
  logic        xfer_discard = 1'b0;
  logic [31:0] cur_addr = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor + model: everything here describes what happens at the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!nRst) begin
        exp_q.delete();
        data_active  = 1'b0;
        xfer_discard = 1'b0;
        model_pc     = RESET_PC;
      end else begin
        check("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
        if (inst_valid && inst_ready && !redirect && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst_data", inst_data, e.data);
          $display("retire pc=%h data=%h", inst_pc, inst_data);
        end
        if (data_active && HREADY) begin
          if (!xfer_discard && !redirect) begin
            e.pc   = cur_addr;
            e.data = HRDATA;
            exp_q.push_back(e);
            model_pc = cur_addr + 32'd4;
            check("fifo_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
          end
          data_active = 1'b0;
        end
        if (HTRANS == 2'b10) begin
          check("one_outstanding", 32'(data_active), 32'd0);
          check("busreq_on_issue", 32'(HBUSREQ1), 32'd1);
          check("haddr", HADDR, model_pc);
          issue_log.push_back(HADDR);
          data_active  = 1'b1;
          cur_addr     = HADDR;
          xfer_discard = 1'b0;
        end
        if (redirect) begin
          exp_q.delete();
          model_pc = {redirect_pc[31:2], 2'b00};
          if (data_active) xfer_discard = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
    HGRANT1     = ($urandom_range(99) < grant_pct);
    HREADY      = data_active ? ($urandom_range(99) < hready_pct) : 1'b1;
    HRDATA      = (data_active && data_mode == 0) ? cur_addr + 32'h100 : $urandom;
    inst_ready  = ($urandom_range(99) < iready_pct);
    redirect    = ($urandom_range(99) < redirect_pct);
    redirect_pc = $urandom;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busreq"}, 32'(HBUSREQ1), 32'd0);
    check({tag, "_haddr"}, HADDR, 32'd0);
    check({tag, "_htrans"}, 32'(HTRANS), 32'd0);
    check({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_data"}, inst_data, 32'd0);
    check({tag, "_pc"}, inst_pc, 32'd0);
  endtask

  // Steps until the log grows past idx; reports whether it did.
  task automatic wait_issue(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (issue_log.size() > idx) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic expect_issue(input string name, input int idx, input logic [31:0] addr);
    bit ok;
    wait_issue(idx, 40, ok);
    if (ok) check(name, issue_log[idx], addr);
    else check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int  log0;
    bit  found;

    // reset state
    run(3);
    check_reset_outputs("reset");

    // straight-line fetch from reset
    grant_pct = 100; hready_pct = 100; iready_pct = 100; redirect_pct = 0; data_mode = 0;
    nRst = 1'b1;
    for (int i = 0; i < 4; i++) expect_issue("seq_haddr", i, RESET_PC + 32'(i * 4));
    run(10);

    // back-pressure: exactly DEPTH fetches, then one more per pop
    iready_pct = 0;
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    log0 = issue_log.size();
    run(40);
    check("full_fetches", 32'(issue_log.size() - log0), 32'd4);
    check("full_busreq", 32'(HBUSREQ1), 32'd0);
    check("full_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    log0 = issue_log.size();
    run(40);
    check("one_pop_fetches", 32'(issue_log.size() - log0), 32'd1);
    check("one_pop_busreq", 32'(HBUSREQ1), 32'd0);

    // full FIFO drains in order while fetching continues
    iready_pct = 100;
    run(40);

    // redirect during a stalled data phase
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (data_active) begin
        found = 1'b1;
        break;
      end
    end
    check("redir_reach_data", 32'(found), 32'd1);
    HREADY = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_2003;
    log0 = issue_log.size();
    step(); HREADY = 1'b0;
    step(); HREADY = 1'b0;
    expect_issue("redir_haddr", log0, 32'h0000_2000);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (inst_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("redir_valid_seen", 32'(found), 32'd1);
    check("redir_first_pc", inst_pc, 32'h0000_2000);
    check("redir_first_data", inst_data, 32'h0000_2100);

    // grant withheld for 5 cycles after reset
    grant_pct = 0;
    step();
    nRst = 1'b0;
    run(2);
    nRst = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check("nogrant_busreq", 32'(HBUSREQ1), 32'd1);
      check("nogrant_htrans", 32'(HTRANS), 32'd0);
      step();
    end
    HGRANT1 = 1'b1;
    grant_pct = 100;
    step();
    check("grant_htrans", 32'(HTRANS), 32'h2);
    check("grant_haddr", HADDR, RESET_PC);

    // fetch address wraps through zero
    step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF4;
    step();
    log0 = issue_log.size();
    expect_issue("wrap_fff4", log0, 32'hFFFF_FFF4);
    expect_issue("wrap_fffc", log0 + 2, 32'hFFFF_FFFC);
    expect_issue("wrap_zero", log0 + 3, 32'h0000_0000);
    run(10);

    // reset pulse in the middle of the data phase at 0x40
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (data_active && cur_addr == 32'h0000_0040) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_reach_data", 32'(found), 32'd1);
    HREADY = 1'b0;
    #2 nRst = 1'b0;
    #1 check_reset_outputs("midrst");
    run(2);
    nRst = 1'b1;
    log0 = issue_log.size();
    expect_issue("rst_first_haddr", log0, RESET_PC);

    // randomized traffic
    data_mode = 1;
    for (int p = 0; p < 6; p++) begin
      grant_pct    = $urandom_range(100, 40);
      hready_pct   = $urandom_range(100, 30);
      iready_pct   = $urandom_range(100, 0);
      redirect_pct = $urandom_range(3, 0);
      run(500);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
